// File: rtl/barrel_packer_acc_if.sv
// Streaming handshake bundle for barrel_packer_acc: field input side and
// packed-word output side, each with its own valid/ready pair.
interface barrel_packer_acc_if #(
    parameter int I_WIDTH  = 128,
    parameter int O_WIDTH  = 128,
    parameter int LEN_BIT  = $clog2(I_WIDTH + 1),
    parameter int FILL_BIT = $clog2(I_WIDTH + O_WIDTH + 1)
);
    logic                i_valid;
    logic                o_ready;
    logic [I_WIDTH-1:0]  i_word;
    logic [LEN_BIT-1:0]  i_len;
    logic                i_comp_flag;
    logic                i_last;
    logic                o_valid;
    logic                i_ready;
    logic [O_WIDTH-1:0]  o_word;
    logic [FILL_BIT-1:0] o_fill;
    logic                o_last;

    // Upstream compressor plus downstream buffer view.
    modport master (
        output i_valid, i_word, i_len, i_comp_flag, i_last, i_ready,
        input  o_ready, o_valid, o_word, o_fill, o_last
    );

    // Packer view.
    modport slave (
        input  i_valid, i_word, i_len, i_comp_flag, i_last, i_ready,
        output o_ready, o_valid, o_word, o_fill, o_last
    );
endinterface

// File: rtl/barrel_packer_acc.sv
// Streaming bit packer: variable-length fields are shifted LSB-first into an
// accumulator at the current fill position; full O_WIDTH words drain out, and
// an end-of-block flush emits the zero-padded remainder tagged o_last.
module barrel_packer_acc #(
    parameter int I_WIDTH  = 128,
    parameter int O_WIDTH  = 128,
    parameter int LEN_BIT  = $clog2(I_WIDTH + 1),
    parameter int FILL_BIT = $clog2(I_WIDTH + O_WIDTH + 1)
) (
    input logic                i_clk,
    input logic                i_rst_n,
    barrel_packer_acc_if.slave bus
);
    localparam int                  ACC_W = I_WIDTH + O_WIDTH;
    localparam logic [FILL_BIT-1:0] O_W_F = FILL_BIT'(O_WIDTH);
    localparam logic [LEN_BIT-1:0]  I_W_L = LEN_BIT'(I_WIDTH);

    logic [ACC_W-1:0]          acc;
    logic [FILL_BIT-1:0]       fill;
    logic                      flush_pending;

    logic                      o_valid_w;
    logic                      o_last_w;
    logic                      o_ready_w;
    logic                      pop;
    logic                      push;
    logic [LEN_BIT-1:0]        eff_len;
    logic [I_WIDTH-1:0]        field;
    logic [FILL_BIT-1:0]       fill_b;
    logic [ACC_W-1:0]          acc_b;
    logic [FILL_BIT:0][ACC_W-1:0] stg;

    // Output side is a pure function of state, so it holds while stalled.
    assign o_valid_w = (fill >= O_W_F) || flush_pending;
    assign o_last_w  = flush_pending && (fill <= O_W_F);
    assign o_ready_w = i_rst_n && !flush_pending && ((fill < O_W_F) || bus.i_ready);

    assign bus.o_valid = o_valid_w;
    assign bus.o_last  = o_last_w;
    assign bus.o_ready = o_ready_w;
    assign bus.o_word  = acc[O_WIDTH-1:0];
    assign bus.o_fill  = (fill >= O_W_F) ? O_W_F : fill;

    assign pop  = o_valid_w && bus.i_ready;
    assign push = bus.i_valid && o_ready_w;

    // Effective length: raw beats are full width, compressed ones clamp to I_WIDTH.
    always_comb begin
        eff_len = bus.i_len;
        if (!bus.i_comp_flag || (bus.i_len > I_W_L))
            eff_len = I_W_L;
    end

    // Drop field bits at or above the effective length (shift by I_WIDTH gives all-ones).
    assign field = bus.i_word & ~({I_WIDTH{1'b1}} << eff_len);

    // A pop retires the low word first; the push then lands on what remains.
    assign acc_b  = pop ? (acc >> O_WIDTH) : acc;
    assign fill_b = pop ? (o_last_w ? '0 : fill - O_W_F) : fill;

    // Log2 barrel shifter: stage k shifts by 2**k when fill_b[k] is set.
    assign stg[0] = ACC_W'(field);
    for (genvar k = 0; k < FILL_BIT; k++) begin : g_shf
        assign stg[k+1] = fill_b[k] ? (stg[k] << (2**k)) : stg[k];
    end

    // Accumulator, fill count and flush tracking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc           <= '0;
            fill          <= '0;
            flush_pending <= 1'b0;
        end else begin
            acc  <= push ? (acc_b | stg[FILL_BIT]) : acc_b;
            fill <= push ? (fill_b + FILL_BIT'(eff_len)) : fill_b;
            if (push && bus.i_last)
                flush_pending <= 1'b1;
            else if (pop && o_last_w)
                flush_pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_barrel_packer_acc.sv
// Bench for barrel_packer_acc: a bit-list reference model fills a scoreboard
// of expected words as beats are accepted; a negedge monitor checks each pop.
module tb_barrel_packer_acc;
    localparam int IW = 128;
    localparam int OW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pops = 0;
    int   stalls = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    barrel_packer_acc_if #(.I_WIDTH(IW), .O_WIDTH(OW)) bus ();

    barrel_packer_acc #(.I_WIDTH(IW), .O_WIDTH(OW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [127:0] w;
        int           fill;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] word;
        logic [7:0]   len;
        logic         comp;
        logic         last;
        logic         rdy;
        logic         drain;
        logic         exp_valid;
        logic         exp_last;
        logic [8:0]   exp_fill;
        logic [127:0] exp_word;
    } vec_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [383:0] mbuf = '0;
    int           mcnt = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: keep accepted bits as a flat list, cut into words.
    task automatic model_push(input logic [127:0] w, input logic [7:0] len,
                              input logic comp, input logic last);
        int l;
        exp_t e;
        l = !comp ? IW : ((int'(len) > IW) ? IW : int'(len));
        for (int i = 0; i < l; i++) mbuf[mcnt + i] = w[i];
        mcnt += l;
        while (last ? (mcnt > OW) : (mcnt >= OW)) begin
            e.w = mbuf[127:0]; e.fill = OW; e.last = 1'b0;
            sbq.push_back(e);
            mbuf = mbuf >> OW;
            mcnt -= OW;
        end
        if (last) begin
            e.w = mbuf[127:0]; e.fill = mcnt; e.last = 1'b1;
            sbq.push_back(e);
            mbuf = '0;
            mcnt = 0;
        end
    endtask

    // Monitor: compare pops against the scoreboard, then feed accepted beats.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid && bus.i_ready) begin
                pops++;
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_unexpected got=%h exp=none", bus.o_word);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_word", bus.o_word, mon_e.w);
                    chk("sb_fill", 128'(bus.o_fill), 128'(mon_e.fill));
                    chk("sb_last", 128'(bus.o_last), 128'(mon_e.last));
                end
            end
            if (bus.i_valid && bus.o_ready)
                model_push(bus.i_word, bus.i_len, bus.i_comp_flag, bus.i_last);
        end
    end

    task automatic set_beat(input logic [127:0] w, input logic [7:0] len,
                            input logic comp, input logic last);
        bus.i_word = w; bus.i_len = len; bus.i_comp_flag = comp;
        bus.i_last = last; bus.i_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic wait_accept(input string name);
        bit ok = 0;
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.o_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            stalls += t;
            @(posedge clk); #1;
        end else begin
            n_cmp++; n_err++;
            $display("FAIL %s_accept got=timeout exp=accept", name);
        end
    endtask

    task automatic send(input logic [127:0] w, input logic [7:0] len,
                        input logic comp, input logic last);
        set_beat(w, len, comp, last);
        wait_accept("send");
    endtask

    task automatic drain();
        bit ok = 0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!bus.o_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drain got=valid_stuck exp=empty");
        end
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[8];
        logic [127:0] ones;
        logic [127:0] w1, w2, wa;
        int           c0, p0, s0;

        ones = '1;
        wa   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        //            word  len     comp  last  rdy   drain vld   lst   fill    exp word
        tbl[0] = '{ones, 8'd5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd5,   128'h1F};
        tbl[1] = '{ones, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd5,   128'h1F};
        tbl[2] = '{'0,   8'd3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd8,   128'h1F};
        tbl[3] = '{ones, 8'd8,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd16,  128'hFF1F};
        tbl[4] = '{ones, 8'd200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd128, ~128'hE0};
        tbl[5] = '{wa,   8'd3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd128,
                   128'h4567_89AB_CDEF_FEDC_BA98_7654_3210_FFFF};
        tbl[6] = '{ones, 8'd4,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'd20,  128'hF_0123};
        tbl[7] = '{ones, 8'd0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0,   128'h0};

        // Reset held with valid input.
        bus.i_ready = 1'b0;
        set_beat(ones, 8'd64, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 128'(bus.o_valid), 128'd0);
        chk("rst_o_ready", 128'(bus.o_ready), 128'd0);
        chk("rst_o_word",  bus.o_word,        128'd0);
        chk("rst_o_fill",  128'(bus.o_fill),  128'd0);
        chk("rst_o_last",  128'(bus.o_last),  128'd0);
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        chk("rst_release_ready", 128'(bus.o_ready), 128'd1);
        @(posedge clk); #1;

        // Pack two 64-bit fields into one word.
        send({64'h0, 64'hAAAA_AAAA_AAAA_AAAA}, 8'd64, 1'b1, 1'b0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("pack_latency_fill", 128'(bus.o_fill), 128'd64);
        chk("pack_latency_word", bus.o_word, {64'h0, 64'hAAAA_AAAA_AAAA_AAAA});
        @(posedge clk); #1;
        send({64'h0, 64'h5555_5555_5555_5555}, 8'd64, 1'b1, 1'b0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("pack_word", bus.o_word, {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA});
        chk("pack_fill", 128'(bus.o_fill), 128'd128);
        chk("pack_last", 128'(bus.o_last), 128'd0);
        @(posedge clk); #1;
        drain();

        // Streaming raw beats at full rate.
        bus.i_ready = 1'b1;
        c0 = cyc; p0 = pops; s0 = stalls;
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom, $urandom, $urandom}, 8'd0, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        chk("stream_stalls", 128'(stalls - s0), 128'd0);
        chk("stream_cycles", 128'(cyc - c0), 128'd8);
        @(negedge clk);
        chk("stream_tail_valid", 128'(bus.o_valid), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_empty", 128'(bus.o_valid), 128'd0);
        chk("stream_pops", 128'(pops - p0), 128'd8);
        @(posedge clk); #1;
        bus.i_ready = 1'b0;

        // Flush remainder: 3 x 50 bits, last on the third.
        send({$urandom, $urandom, $urandom, $urandom}, 8'd50, 1'b1, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 8'd50, 1'b1, 1'b0);
        send(ones, 8'd50, 1'b1, 1'b1);
        bus.i_valid = 1'b1;
        @(negedge clk);
        chk("flush_w1_fill", 128'(bus.o_fill), 128'd128);
        chk("flush_w1_last", 128'(bus.o_last), 128'd0);
        chk("flush_ready_lo0", 128'(bus.o_ready), 128'd0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("flush_ready_lo1", 128'(bus.o_ready), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_w2_fill", 128'(bus.o_fill), 128'd22);
        chk("flush_w2_last", 128'(bus.o_last), 128'd1);
        chk("flush_w2_pad", bus.o_word >> 22, 128'd0);
        chk("flush_ready_lo2", 128'(bus.o_ready), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_ready_back", 128'(bus.o_ready), 128'd1);
        chk("flush_idle", 128'(bus.o_valid), 128'd0);
        @(posedge clk); #1;
        bus.i_ready = 1'b0;

        // Backpressure: full word held 5 cycles, then pop + accept together.
        w1 = {$urandom, $urandom, $urandom, $urandom};
        w2 = {$urandom, $urandom, $urandom, $urandom};
        send(w1, 8'd0, 1'b0, 1'b0);
        set_beat(w2, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 128'(bus.o_ready), 128'd0);
            chk("bp_valid", 128'(bus.o_valid), 128'd1);
            chk("bp_word",  bus.o_word, w1);
            chk("bp_fill",  128'(bus.o_fill), 128'd128);
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        s0 = stalls;
        wait_accept("bp");
        chk("bp_same_cycle", 128'(stalls - s0), 128'd0);
        drain();

        // Clamp / mask / zero-length / empty flush table.
        foreach (tbl[i]) begin
            bus.i_ready = tbl[i].rdy;
            send(tbl[i].word, tbl[i].len, tbl[i].comp, tbl[i].last);
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 128'(bus.o_valid), 128'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_fill", i),  128'(bus.o_fill),  128'(tbl[i].exp_fill));
            chk($sformatf("tbl%0d_word", i),  bus.o_word,        tbl[i].exp_word);
            chk($sformatf("tbl%0d_last", i),  128'(bus.o_last),  128'(tbl[i].exp_last));
            @(posedge clk); #1;
            if (tbl[i].drain) drain();
        end

        chk("sb_leftover", 128'(sbq.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/barrel_packer_acc.md
# barrel_packer_acc

Parametrised, streaming successor to the compression-path barrel shifter. It accepts variable-length compressed fields (or raw words when compression is off) over a valid/ready handshake. Each field is shifted into an accumulator at the current fill position, LSB-first. Fixed-width packed words are emitted downstream, and a final zero-padded partial word is emitted on end-of-block flush. It sits between the compressor output and the line/packet buffer.

## Interface
- I_WIDTH, 128, input field width in bits
- O_WIDTH, 128, output word width in bits; I_WIDTH <= O_WIDTH is required
- LEN_BIT, $clog2(I_WIDTH+1), width of the length field
- FILL_BIT, $clog2(I_WIDTH+O_WIDTH+1), width of the fill count and o_fill (derived)
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_word  in  I_WIDTH  field bits, LSB-aligned
- i_len  in  LEN_BIT  number of valid bits in i_word; values > I_WIDTH are clamped to I_WIDTH
- i_comp_flag  in  1  1: use i_len; 0: raw word, length forced to I_WIDTH
- i_last  in  1  last beat of block; requests flush
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_word  out  O_WIDTH  packed word; bits at and above o_fill are zero
- o_fill  out  FILL_BIT  number of valid bits in o_word (O_WIDTH for full words)
- o_last  out  1  final word of block

## Operation
- State: accumulator acc[I_WIDTH+O_WIDTH-1:0], fill count, flush_pending flag.
- Effective length: L = i_comp_flag ? min(i_len, I_WIDTH) : I_WIDTH. Bits of i_word at positions >= L are masked to 0 before shifting.
- Pop: occurs when o_valid && i_ready. acc shifts right by O_WIDTH (zero fill) and fill decrements by O_WIDTH, or clears to 0 if the popped word was o_last.
- Base fill: fill_b = fill after any pop this cycle.
- Push: on acceptance, the masked field is shifted left by fill_b through a log2 barrel shifter and ORed into acc. New fill = fill_b + L.
- o_ready = i_rst_n && !flush_pending && (fill < O_WIDTH || i_ready). Because I_WIDTH <= O_WIDTH, fill_b + L never exceeds I_WIDTH+O_WIDTH.
- o_valid = (fill >= O_WIDTH) || flush_pending.
- o_word = acc[O_WIDTH-1:0]; o_fill = min(fill, O_WIDTH).
- o_last = flush_pending && fill <= O_WIDTH.
- Flush:
  - An accepted beat with i_last sets flush_pending; that beat's bits are included.
  - Full words drain first.
  - The word with fill <= O_WIDTH is emitted with o_last=1. flush_pending clears on its pop.
  - If fill == 0 at flush, one empty word is emitted: o_word=0, o_fill=0, o_last=1.
- L = 0 beats are accepted; fill is unchanged. A zero-length beat with i_last still triggers a flush.
- Downstream stall: o_word, o_fill and o_last hold stable while o_valid && !i_ready.
- Reset values: acc=0, fill=0, flush_pending=0, o_valid=0, o_word=0, o_fill=0, o_last=0. o_ready=0 while i_rst_n=0.
- Reset mid-block discards all accumulated bits and any pending flush.

## Timing
- Latency: bits of a beat accepted in cycle N appear in o_word from cycle N+1.
- Throughput: with i_ready held at 1, one beat is accepted every cycle, including raw full-width beats (fill oscillates, never stalls).
- o_ready depends combinationally on i_ready. No other combinational input-to-output paths.
- The cycle after an i_last acceptance, o_ready=0 until the o_last pop. The next block's first beat can be accepted the cycle after that pop.
- Pop and push in the same cycle: the pop is applied first, and the push lands at fill_b.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles with i_valid=1 -> o_valid=0, o_ready=0, o_word=0, o_fill=0, o_last=0. Release -> o_ready=1.
- Pack: two beats, L=64 each, words 64'hAAAA_AAAA_AAAA_AAAA then 64'h5555_5555_5555_5555 -> one word {5555..., AAAA...}, o_fill=128, o_last=0.
- Streaming raw: 8 back-to-back beats, i_comp_flag=0, i_ready=1 -> o_ready stays 1, 8 output words equal to the inputs in order, one per cycle starting 1 cycle after the first accept.
- Flush remainder: 3 beats of L=50, third with i_last -> word 1 has o_fill=128 and o_last=0. Word 2 has o_fill=22, o_last=1, and bits [127:22]=0. o_ready is 0 until word 2 pops.
- Backpressure: fill >= 128 with i_ready=0 for 5 cycles -> o_ready=0, o_valid=1, o_word/o_fill stable. Raise i_ready -> pop, and a beat is accepted in the same cycle.
- Clamp/mask/empty:
  - i_len=200, i_word all-ones -> fill += 128.
  - i_len=5, i_word all-ones -> only 5 ones are added.
  - Lone i_last beat with i_len=0 at fill 0 -> single word with o_fill=0, o_last=1, o_word=0.
